branch_predictor_unit: RTL
==========================

Name: branch_predictor_unit

Overview:
- Parametrised successor to the single-bit bimodal predictor in the pipelined RISC-V core.
- Pattern history table (PHT) of CTR_BITS-wide saturating counters plus a direct-mapped branch target buffer (BTB) with tags; optional gshare indexing with a global history register (GHR).
- Lookup is combinational from the IF-stage PC. The lookup index travels down the pipe. Update is registered at branch resolution (EX/MEM).
- Also keeps saturating performance counters for lookups-resolved and mispredicts.

Parameters:
- PC_WIDTH, 64, width of all PC/target buses.
- INDEX_BITS, 6, log2 of PHT and BTB entry count (64 entries).
- CTR_BITS, 2, saturating counter width (>=1).
- TAG_BITS, 8, BTB tag width, taken from PC[INDEX_BITS+2+TAG_BITS-1 : INDEX_BITS+2].
- HIST_BITS, 6, GHR width (<= INDEX_BITS); used only with the optional feature.
- STAT_BITS, 32, performance counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- lk_pc  in  PC_WIDTH  fetch PC to predict.
- pred_taken  out  1  predict taken.
- pred_target  out  PC_WIDTH  predicted next PC.
- pred_index  out  INDEX_BITS  PHT index used; carried down the pipe to the update port.
- upd_valid  in  1  a conditional branch resolved this cycle.
- upd_pc  in  PC_WIDTH  resolved branch PC.
- upd_index  in  INDEX_BITS  pred_index captured at this branch's fetch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_WIDTH  actual taken target.
- upd_pred_taken  in  1  prediction made at fetch.
- mispredict  out  1  registered; pulses one cycle after a mispredicted update.
- stat_branches  out  STAT_BITS  resolved-branch count.
- stat_mispred  out  STAT_BITS  mispredict count.

Behaviour:
- Indexing:
  - Base index = lk_pc[INDEX_BITS+1:2].
  - With gshare, the low HIST_BITS of the index are XORed with GHR.
  - pred_index is driven with this index.
- Lookup (combinational, zero latency):
  - BTB hit = entry valid AND stored tag equals lk_pc tag field.
  - pred_taken = PHT[idx] MSB AND hit. The BTB is indexed by the base index, never hashed.
  - pred_target = BTB target when pred_taken; otherwise lk_pc + 4, modulo 2^PC_WIDTH.
- Update (when upd_valid, at the clock edge):
  - PHT[upd_index] increments if upd_taken, decrements otherwise.
  - Counters saturate at 2^CTR_BITS-1 and at 0; no wrap.
  - When upd_taken, the BTB entry at upd_pc's base index is written with valid=1, the tag and upd_target.
  - Not-taken updates leave the BTB untouched.
- mispredict register <= upd_valid AND (upd_pred_taken != upd_taken); 0 when upd_valid=0.
- Target mismatch is not counted here; EX handles redirect.
- stat_branches increments on each upd_valid. stat_mispred increments on each mispredict condition. Both saturate at all-ones.
- Read-during-write: a lookup in the same cycle as an update to the same entry sees the pre-update value. The new value is visible the following cycle.
- Reset values:
  - All PHT counters = 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2-bit).
  - All BTB valid bits = 0. Tags and targets need no reset.
  - GHR = 0, mispredict = 0, stats = 0.
  - Consequence: pred_taken = 0 for every PC from the first cycle after reset.
- Reset asserted alongside upd_valid: reset wins and the update is discarded.
- No stall/flush input. Updates from wrong-path instructions must not be presented by the pipeline.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - GHR of HIST_BITS exists.
  - On upd_valid, GHR <= {GHR[HIST_BITS-2:0], upd_taken}; history is non-speculative, updated at resolution.
  - Index hashing as above.
- Undefined:
  - No GHR flops; index = base index only (pure bimodal).
  - HIST_BITS is ignored.

Test Plan:
- Reset with INDEX_BITS=4, CTR_BITS=2 -> for lk_pc=0x0, 0x40, 0x3C: pred_taken=0 and pred_target=pc+4 (0x4, 0x44, 0x40); stats=0.
- Two taken updates at upd_pc=0x20 (upd_index=8, target=0x100), then lookup at 0x20:
  - After the first update: counter 01->10, BTB hit, so pred_taken=1, target=0x100.
  - A third taken update saturates at 11.
  - Three not-taken updates then bring it to 00; a fourth stays 00 and pred_taken=0.
- Tag alias: train 0x20 taken, then lookup 0x20+(1<<6)=0x60 (same index, different tag) -> pred_taken=0, target=0x64.
- Same-cycle update and lookup of entry 8 -> pred_taken reflects the old counter that cycle and the new one the next cycle.
- upd_pred_taken=1, upd_taken=0 -> mispredict=1 for exactly one cycle, stat_mispred=1, stat_branches=1; a correct update gives mispredict=0.
- With BP_GSHARE_EN, HIST_BITS=4:
  - After updates T,T,N, GHR=0b0110.
  - lookup at 0x20 gives pred_index = 8 XOR 6 = 14.
  - Without the macro, pred_index = 8.

Source files
------------

// File: rtl/branch_predictor_unit.sv
// Bimodal/gshare branch predictor: saturating-counter PHT plus tagged direct-mapped BTB.
// Define BP_GSHARE_EN to hash the PHT lookup index with a non-speculative global history.
module branch_predictor_unit #(
  parameter int PC_WIDTH   = 64,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int TAG_BITS   = 8,
  parameter int HIST_BITS  = 6,
  parameter int STAT_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   lk_pc,
  output logic                  pred_taken,
  output logic [PC_WIDTH-1:0]   pred_target,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  input  logic                  upd_pred_taken,
  output logic                  mispredict,
  output logic [STAT_BITS-1:0]  stat_branches,
  output logic [STAT_BITS-1:0]  stat_mispred
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LSB = INDEX_BITS + 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] pht_q     [ENTRIES];
  logic [ENTRIES-1:0]  btb_valid_q;
  logic [TAG_BITS-1:0] btb_tag_q [ENTRIES];
  logic [PC_WIDTH-1:0] btb_tgt_q [ENTRIES];

  logic [INDEX_BITS-1:0] lk_base;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] upd_base;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  btb_hit;

  logic [CTR_BITS-1:0]   ctr_cur;
  logic [CTR_BITS-1:0]   ctr_d;

  logic                  mispredict_q, mispredict_d;
  logic [STAT_BITS-1:0]  stat_branches_q, stat_branches_d;
  logic [STAT_BITS-1:0]  stat_mispred_q, stat_mispred_d;
  logic                  mis_cond;

  assign lk_base  = lk_pc[INDEX_BITS+1:2];
  assign upd_base = upd_pc[INDEX_BITS+1:2];
  assign lk_tag   = lk_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];
  assign upd_tag  = upd_pc[TAG_LSB+TAG_BITS-1:TAG_LSB];

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [INDEX_BITS-1:0] ghr_ext;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_BITS-1:0] = ghr_q;
  end

  assign lk_idx = lk_base ^ ghr_ext;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = {ghr_q[HIST_BITS-2:0], upd_taken};
  end

  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  localparam int unused_hist_bits = HIST_BITS;
  assign lk_idx = lk_base;
`endif

  // Only the index and tag fields of the PCs feed the tables.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc, upd_pc};

  // BTB is always addressed by the unhashed PC index.
  assign btb_hit     = btb_valid_q[lk_base] && (btb_tag_q[lk_base] == lk_tag);
  assign pred_taken  = pht_q[lk_idx][CTR_BITS-1] && btb_hit;
  assign pred_target = pred_taken ? btb_tgt_q[lk_base] : lk_pc + PC_WIDTH'(4);
  assign pred_index  = lk_idx;

  always_comb begin
    ctr_cur = pht_q[upd_index];
    ctr_d   = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_BITS'(1);
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
      btb_valid_q <= '0;
    end else if (upd_valid) begin
      pht_q[upd_index] <= ctr_d;
      if (upd_taken) btb_valid_q[upd_base] <= 1'b1;
    end
  end

  // Tag/target storage carries no reset; the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (!reset && upd_valid && upd_taken) begin
      btb_tag_q[upd_base] <= upd_tag;
      btb_tgt_q[upd_base] <= upd_target;
    end
  end

  assign mis_cond = upd_valid && (upd_pred_taken != upd_taken);

  always_comb begin
    mispredict_d    = mis_cond;
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (upd_valid && !(&stat_branches_q)) stat_branches_d = stat_branches_q + STAT_BITS'(1);
    if (mis_cond && !(&stat_mispred_q))   stat_mispred_d  = stat_mispred_q + STAT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mispredict_q    <= 1'b0;
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      mispredict_q    <= mispredict_d;
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign mispredict    = mispredict_q;
  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule
